vga_frame_scheduler: RTL and testbench
======================================

Name: vga_frame_scheduler

Overview:
- Owns the 640x480@60 VGA raster: pixel-tick divider, hCount/vCount counters, registered hSync/vSync/videoOn.
- Schedules Game-of-Life generation updates into vertical blanking using a req/ack/done handshake with the life engine.
- Issues a frame-aligned bufSwap pulse so the display never sees a half-written generation.
- Sits between the top-level clock domain and the life engine / framebuffer mux.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT_PORCH, 16, pixels
- H_SYNC_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels (line total 800)
- V_ACTIVE, 480, visible lines
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines (frame total 525)
- CLK_DIV, 4, clk cycles per pixel; must be ≥1
- GEN_FRAMES, 8, displayed frames per generation in run mode; must be ≥1

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- run, in, 1, level: free-running generation updates
- step, in, 1, one-cycle pulse: request exactly one generation
- updateAck, in, 1, engine accepted updateReq
- updateDone, in, 1, one-cycle pulse: engine finished writing back buffer
- pixelTick, out, 1, high one clk per pixel period
- hCount, out, $clog2(800), horizontal position
- vCount, out, $clog2(525), vertical position
- hSync, out, 1, active low
- vSync, out, 1, active low
- videoOn, out, 1, high in the 640x480 visible area
- frameStart, out, 1, one-cycle pulse when counters move to (0,0)
- updateReq, out, 1, level request to the engine
- bufSwap, out, 1, one-cycle pulse: exchange front and back buffers
- overrun, out, 1, sticky: an update missed its vblank

Behaviour:
- Reset (async, rst_n=0):
  - divider=0, hCount=0, vCount=0.
  - hSync=1, vSync=1, videoOn=1 (consistent with position (0,0)).
  - pixelTick, frameStart, updateReq, bufSwap, overrun all 0.
  - FSM=IDLE; pending=0; frame counter=0.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixelTick is high when divider==CLK_DIV-1.
  - Counters advance on that clock edge, so the first advance occurs CLK_DIV clocks after reset release.
- Counters:
  - hCount wraps 799→0.
  - vCount increments on the hCount wrap and wraps 524→0.
- Sync and video outputs:
  - hSync, vSync and videoOn are registered, updated on the same edge as the counters, and always consistent with the current counter values.
  - hSync=0 for hCount in [656,751].
  - vSync=0 for vCount in [490,491].
  - videoOn=1 iff hCount<640 && vCount<480.
- frameStart is high the cycle the counters hold (0,0) after a wrap. It is not asserted after reset.
- vblankEntry (internal) is high the cycle the counters first hold (0,480).
- Frame counter:
  - Increments on each frameStart while run=1.
  - Held at 0 while run=0.
  - When the count reaches GEN_FRAMES: pending is set and the counter clears.
- pending:
  - Also set by step.
  - One deep: extra triggers while pending=1 are dropped.
- FSM states:
  - IDLE: if pending && vblankEntry, go to REQ and clear pending. A step arriving in the vblankEntry cycle is served in that same frame.
  - REQ: updateReq=1. When updateAck=1 (ack in the first REQ cycle is legal), go to BUSY and drop updateReq the next cycle.
  - BUSY: wait for updateDone. If updateDone arrives without frameStart, go to SWAP.
  - SWAP: on the next frameStart, assert bufSwap in that same cycle and go to IDLE.
- Overrun:
  - frameStart in REQ or BUSY sets overrun (sticky until reset). There is no swap and the state is kept; the swap follows at the first frameStart after done.
  - updateDone and frameStart in the same BUSY cycle: bufSwap asserted that cycle, go to IDLE, no overrun.
- Triggers arriving in REQ/BUSY/SWAP set pending. They are served at the first vblankEntry after the FSM returns to IDLE.
- run falling mid-update does not abort; the in-flight update completes and swaps.
- Reset mid-operation: all state returns to reset values immediately; updateReq drops asynchronously.

Optional Feature:
- Macro: VGA_GEN_COUNTER_EN.
- Defined:
  - Adds output port genCount[15:0], reset 0.
  - Increments on each bufSwap and wraps 65535→0.
- Undefined: port absent; no counter logic.

Test Plan:
- Reset release, CLK_DIV=4: first pixelTick at clk 4. hSync low for exactly 96 ticks starting at hCount=656. vSync low on vCount 490–491 only. frameStart every 1,680,000 clks.
- run=0, step pulse mid-frame; engine acks after 3 clks and sends done 1000 clks later. Required: updateReq at the next (0,480), bufSwap coincident with the next frameStart, overrun=0.
- run=1, GEN_FRAMES=8, engine done within vblank. Required: exactly one bufSwap per 8 frameStarts over 32 frames, for 4 swaps total.
- Engine holds done past the next frameStart. Required: overrun=1 at that frameStart with no bufSwap; bufSwap at the following frameStart after done; overrun stays 1.
- updateDone and frameStart in the same cycle. Required: bufSwap that cycle, overrun=0. Also two step pulses during BUSY: exactly one extra update, at the next vblankEntry.
- rst_n low while in BUSY with updateReq history. Required: all outputs at reset values immediately. With VGA_GEN_COUNTER_EN defined, genCount=0 and equals the bufSwap count afterwards.

Source files
------------

// File: rtl/vga_frame_scheduler.sv
// VGA raster timing plus vblank-aligned scheduling of life-engine generation updates.
// Optional macro VGA_GEN_COUNTER_EN adds a 16-bit genCount of completed buffer swaps.
module vga_frame_scheduler #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int CLK_DIV       = 4,
    parameter int GEN_FRAMES    = 8,
    localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
    localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          step,
    input  logic          updateAck,
    input  logic          updateDone,
    output logic          pixelTick,
    output logic [HW-1:0] hCount,
    output logic [VW-1:0] vCount,
    output logic          hSync,
    output logic          vSync,
    output logic          videoOn,
    output logic          frameStart,
    output logic          updateReq,
    output logic          bufSwap,
    output logic          overrun
`ifdef VGA_GEN_COUNTER_EN
    ,
    output logic [15:0]   genCount
`endif
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = $clog2(GEN_FRAMES + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FRONT_PORCH);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FRONT_PORCH);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE - 1);
    localparam logic [FW-1:0] GEN_LAST = FW'(GEN_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_SWAP} state_t;

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_q, video_d;
    logic          frame_start_q, frame_start_d;
    logic          vblank_entry_q, vblank_entry_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          pending_q, pending_d;
    state_t        state_q, state_d;
    logic          update_req_q, update_req_d;
    logic          overrun_q, overrun_d;
    logic          tick, h_wrap, v_wrap, gen_trig, trigger, buf_swap;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;

        h_wrap = tick && (h_q == H_LAST);
        v_wrap = h_wrap && (v_q == V_LAST);
        h_d    = tick ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
        v_d    = h_wrap ? (v_wrap ? '0 : v_q + 1'b1) : v_q;

        // Sync/video are derived from the next position so they stay aligned with the counters.
        hsync_d        = !((h_d >= HS_START) && (h_d <= HS_END));
        vsync_d        = !((v_d >= VS_START) && (v_d <= VS_END));
        video_d        = (h_d < H_VIS) && (v_d < V_VIS);
        frame_start_d  = v_wrap;
        vblank_entry_d = h_wrap && (v_d == V_VIS);

        gen_trig    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (!run) begin
            frame_cnt_d = '0;
        end else if (frame_start_q) begin
            if (frame_cnt_q == GEN_LAST) begin
                frame_cnt_d = '0;
                gen_trig    = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        trigger = step || gen_trig;

        state_d      = state_q;
        update_req_d = update_req_q;
        overrun_d    = overrun_q;
        pending_d    = pending_q || trigger;
        buf_swap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A trigger landing in the vblank-entry cycle is served immediately.
                if ((pending_q || trigger) && vblank_entry_q) begin
                    state_d      = S_REQ;
                    update_req_d = 1'b1;
                    pending_d    = 1'b0;
                end
            end
            S_REQ: begin
                if (frame_start_q) overrun_d = 1'b1;
                if (updateAck) begin
                    state_d      = S_BUSY;
                    update_req_d = 1'b0;
                end
            end
            S_BUSY: begin
                if (updateDone && frame_start_q) begin
                    buf_swap = 1'b1;
                    state_d  = S_IDLE;
                end else if (updateDone) begin
                    state_d = S_SWAP;
                end else if (frame_start_q) begin
                    overrun_d = 1'b1;
                end
            end
            S_SWAP: begin
                if (frame_start_q) begin
                    buf_swap = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q          <= '0;
            h_q            <= '0;
            v_q            <= '0;
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
            video_q        <= 1'b1;
            frame_start_q  <= 1'b0;
            vblank_entry_q <= 1'b0;
            frame_cnt_q    <= '0;
            pending_q      <= 1'b0;
            state_q        <= S_IDLE;
            update_req_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            div_q          <= div_d;
            h_q            <= h_d;
            v_q            <= v_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            video_q        <= video_d;
            frame_start_q  <= frame_start_d;
            vblank_entry_q <= vblank_entry_d;
            frame_cnt_q    <= frame_cnt_d;
            pending_q      <= pending_d;
            state_q        <= state_d;
            update_req_q   <= update_req_d;
            overrun_q      <= overrun_d;
        end
    end

`ifdef VGA_GEN_COUNTER_EN
    logic [15:0] gen_cnt_q, gen_cnt_d;

    always_comb begin
        gen_cnt_d = gen_cnt_q + {15'd0, buf_swap};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gen_cnt_q <= '0;
        else        gen_cnt_q <= gen_cnt_d;
    end

    assign genCount = gen_cnt_q;
`endif

    assign pixelTick  = tick;
    assign hCount     = h_q;
    assign vCount     = v_q;
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign videoOn    = video_q;
    assign frameStart = frame_start_q;
    assign updateReq  = update_req_q;
    assign bufSwap    = buf_swap;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler on a shrunken raster; a cycle-count model predicts the raster
// and directed steps push the frame index at which each buffer swap must occur.
module tb_vga_frame_scheduler;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int CD = 2, GF = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FL = HT * VT * CD;
    localparam int VBE = VA * HT * CD;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          updateAck = 1'b0;
    logic          updateDone = 1'b0;
    logic          pixelTick, hSync, vSync, videoOn, frameStart, updateReq, bufSwap, overrun;
    logic [HW-1:0] hCount;
    logic [VW-1:0] vCount;
`ifdef VGA_GEN_COUNTER_EN
    logic [15:0]   genCount;
`endif

    int          total = 0;
    int          bad = 0;
    int          n = 0;
    int          swaps_ok = 0;
    int          ack_dly = 3;
    int          done_dly = 100;
    bit          done_at_fs = 1'b0;
    logic [31:0] exp_q[$];

    vga_frame_scheduler #(
        .H_ACTIVE(HA), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
        .V_ACTIVE(VA), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB),
        .CLK_DIV(CD), .GEN_FRAMES(GF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .updateAck(updateAck), .updateDone(updateDone),
        .pixelTick(pixelTick), .hCount(hCount), .vCount(vCount),
        .hSync(hSync), .vSync(vSync), .videoOn(videoOn), .frameStart(frameStart),
        .updateReq(updateReq), .bufSwap(bufSwap), .overrun(overrun)
`ifdef VGA_GEN_COUNTER_EN
        , .genCount(genCount)
`endif
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; the whole raster is a function of this.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    function automatic int hpos(input int c); return (c / CD) % HT; endfunction
    function automatic int vpos(input int c); return ((c / CD) / HT) % VT; endfunction
    function automatic int frm(input int c);  return (c / CD) / (HT * VT); endfunction
    function automatic bit fs_exp(input int c);
        return (c > 0) && (c % CD == 0) && (hpos(c) == 0) && (vpos(c) == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (n < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_hCount"}, hCount, 0);
        chk({tag, "_vCount"}, vCount, 0);
        chk({tag, "_hSync"}, hSync, 1);
        chk({tag, "_vSync"}, vSync, 1);
        chk({tag, "_videoOn"}, videoOn, 1);
        chk({tag, "_pixelTick"}, pixelTick, 0);
        chk({tag, "_frameStart"}, frameStart, 0);
        chk({tag, "_updateReq"}, updateReq, 0);
        chk({tag, "_bufSwap"}, bufSwap, 0);
        chk({tag, "_overrun"}, overrun, 0);
`ifdef VGA_GEN_COUNTER_EN
        chk({tag, "_genCount"}, genCount, 0);
`endif
    endtask

    // Raster and swap scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pixelTick", pixelTick, (n % CD) == CD - 1);
            chk("hCount", hCount, hpos(n));
            chk("vCount", vCount, vpos(n));
            chk("hSync", hSync, !(hpos(n) >= HA + HF && hpos(n) <= HA + HF + HS - 1));
            chk("vSync", vSync, !(vpos(n) >= VA + VF && vpos(n) <= VA + VF + VS - 1));
            chk("videoOn", videoOn, hpos(n) < HA && vpos(n) < VA);
            chk("frameStart", frameStart, fs_exp(n));
            if (bufSwap) begin
                if (exp_q.size() == 0) begin
                    chk("swap_expected", exp_q.size(), 1);
                end else begin
                    chk("swap_frame", frm(n), exp_q.pop_front());
                    chk("swap_on_frameStart", frameStart, 1);
                    swaps_ok++;
                end
            end
        end
    end

    // Life-engine model: ack after ack_dly clocks, then done after done_dly or at a frameStart.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (updateReq) begin
                for (int i = 1; i < ack_dly; i++) begin
                    @(posedge clk);
                    #1;
                end
                if (rst_n) begin
                    updateAck = 1'b1;
                    @(posedge clk);
                    #1;
                    updateAck = 1'b0;
                end
                if (done_at_fs) begin
                    for (int i = 0; i < 2 * FL && rst_n && !fs_exp(n); i++) begin
                        @(posedge clk);
                        #1;
                    end
                end else begin
                    for (int i = 0; i < done_dly && rst_n; i++) begin
                        @(posedge clk);
                        #1;
                    end
                end
                if (rst_n) begin
                    updateDone = 1'b1;
                    @(posedge clk);
                    #1;
                    updateDone = 1'b0;
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        goto(CD - 1);
        chk("first_tick", pixelTick, 1);

        // Single step mid-frame with run low; swap at the following frameStart.
        goto(50);
        pulse_step();
        exp_q.push_back(1);
        goto(VBE);
        chk("stepA_req_before_vbe", updateReq, 0);
        goto(VBE + 1);
        chk("stepA_req_after_vbe", updateReq, 1);
        goto(FL + 10);
        chk("stepA_overrun", overrun, 0);
        chk("stepA_queue_empty", exp_q.size(), 0);

        // Run mode: one swap per GEN_FRAMES frameStarts.
        run = 1'b1;
        for (int k = 1; k <= 4; k++) exp_q.push_back(1 + k * GF + 1);
        goto((1 + 4 * GF + 1) * FL + 10);
        run = 1'b0;
        chk("run_queue_empty", exp_q.size(), 0);
        chk("run_overrun", overrun, 0);

        // Engine slow: done lands after the next frameStart.
        done_dly = 300;
        goto(35 * FL + 50);
        pulse_step();
        exp_q.push_back(37);
        goto(36 * FL - 2);
        chk("ovr_before", overrun, 0);
        goto(36 * FL + 1);
        chk("ovr_set", overrun, 1);
        goto(37 * FL + 5);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_queue_empty", exp_q.size(), 0);

        // Reset while BUSY.
        goto(38 * FL + 50);
        pulse_step();
        goto(38 * FL + VBE + 1);
        chk("rst_req_history", updateReq, 1);
        goto(38 * FL + 250);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        swaps_ok = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("held_rst");
        rst_n = 1'b1;

        // Done coincident with frameStart, plus two steps while BUSY.
        done_at_fs = 1'b1;
        goto(50);
        pulse_step();
        exp_q.push_back(1);
        goto(250);
        pulse_step();
        goto(260);
        pulse_step();
        exp_q.push_back(2);
        goto(FL + 10);
        chk("same_cycle_overrun", overrun, 0);
        goto(FL + VBE);
        chk("extra_req_before_vbe", updateReq, 0);
        goto(FL + VBE + 1);
        chk("extra_req_after_vbe", updateReq, 1);
        goto(2 * FL + 10);
        chk("extra_overrun", overrun, 0);
        goto(4 * FL);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_no_req", updateReq, 0);
`ifdef VGA_GEN_COUNTER_EN
        chk("genCount", genCount, swaps_ok);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
